// File: rtl/shift_sched.sv
// Round-robin, time-shared iterative shifter for two requesters (SLL/SRL/SRA).
// Define SHIFT_STEP2_EN to move up to 2 positions per cycle; otherwise 1 per cycle.
module shift_sched #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [3:0]     req_op,
  input  logic [9:0]     req_amt,
  input  logic [2*W-1:0] req_data,
  output logic           res_valid,
  output logic           res_id,
  output logic [W-1:0]   res_data,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state, state_nxt;
  logic         last;
  logic [W-1:0] work;
  logic [1:0]   op;
  logic [4:0]   rem;
  logic         owner;

  logic         grant_id;
  logic         accept;
  logic [1:0]   sel_op;
  logic [4:0]   sel_amt;
  logic [W-1:0] sel_data;
  logic [1:0]   step;
  logic [4:0]   rem_nxt;
  logic [W-1:0] shifted;

  // Both valid: the port that did not win last time gets the stage.
  always_comb begin
    grant_id = (req_valid == 2'b11) ? ~last : req_valid[1];
    accept   = (state == IDLE) && !rst && (req_valid != 2'b00);
    sel_op   = grant_id ? req_op[3:2]      : req_op[1:0];
    sel_amt  = grant_id ? req_amt[9:5]     : req_amt[4:0];
    sel_data = grant_id ? req_data[2*W-1:W] : req_data[W-1:0];
  end

  always_comb begin
`ifdef SHIFT_STEP2_EN
    step = (rem >= 5'd2) ? 2'd2 : 2'd1;
`else
    step = 2'd1;
`endif
    rem_nxt = rem - {3'b000, step};
    case (op)
      2'b01:   shifted = work >> step;
      2'b10:   shifted = $signed(work) >>> step;
      default: shifted = work << step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (sel_amt == 5'd0) ? DONE : SHIFT;
      SHIFT:   if (rem_nxt == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_valid = (state == DONE);
    busy      = (state != IDLE);
    req_ready = 2'b00;
    if (accept) req_ready = grant_id ? 2'b10 : 2'b01;
  end

  // Result registers load on the edge into DONE and hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      work     <= '0;
      op       <= 2'b00;
      rem      <= 5'd0;
      owner    <= 1'b0;
      res_data <= '0;
      res_id   <= 1'b0;
    end else if (accept) begin
      work  <= sel_data;
      op    <= sel_op;
      rem   <= sel_amt;
      owner <= grant_id;
      last  <= grant_id;
      if (sel_amt == 5'd0) begin
        res_data <= sel_data;
        res_id   <= grant_id;
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      rem  <= rem_nxt;
      if (rem_nxt == 5'd0) begin
        res_data <= shifted;
        res_id   <= owner;
      end
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed + randomized bench for shift_sched with an arithmetic reference model.
module tb_shift_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [9:0]  req_amt;
  logic [63:0] req_data;
  logic        res_valid;
  logic        res_id;
  logic [31:0] res_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [1:0]  op_m   [2];
  logic [4:0]  amt_m  [2];
  logic [31:0] data_m [2];
  logic        last_m;
  int          g_m;

  shift_sched #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_amt(req_amt), .req_data(req_data),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                            input logic [31:0] d);
    case (op)
      2'b01:   return d >> amt;
      2'b10:   return $signed(d) >>> amt;
      default: return d << amt;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] amt);
`ifdef SHIFT_STEP2_EN
    return (int'(amt) + 1) / 2 + 1;
`else
    return int'(amt) + 1;
`endif
  endfunction

  task automatic drive(input logic [1:0] mask);
    req_valid = mask;
    req_op    = {op_m[1], op_m[0]};
    req_amt   = {amt_m[1], amt_m[0]};
    req_data  = {data_m[1], data_m[0]};
  endtask

  // Enters at the next falling edge (DUT expected idle), returns at the falling edge of DONE.
  task automatic issue(input logic [1:0] mask);
    int g, k, bcnt, lat;
    logic [31:0] exp_d;
    @(negedge clk);
    drive(mask);
    #1;
    g = (mask == 2'b11) ? (last_m ? 0 : 1) : (mask[1] ? 1 : 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("grant", {30'd0, req_ready}, {30'd0, 2'b01 << g});
    exp_d = ref_shift(op_m[g], amt_m[g], data_m[g]);
    lat   = ref_lat(amt_m[g]);
    last_m = g[0];
    g_m    = g;
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    bcnt = 0;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (busy) bcnt++;
      if (res_valid) break;
    end
    chk("latency", k, lat);
    chk("busy_cycles", bcnt, lat);
    chk("res_data", res_data, exp_d);
    chk("res_id", {31'd0, res_id}, g);
  endtask

  initial begin
    logic [1:0] pend, mask;
    logic [31:0] held;
    rst = 1'b1;
    last_m = 1'b1;
    g_m = 0;
    for (int p = 0; p < 2; p++) begin
      op_m[p] = 2'b00; amt_m[p] = 5'd0; data_m[p] = 32'd0;
    end
    drive(2'b00);
    repeat (3) @(negedge clk);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_id", {31'd0, res_id}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Contention from reset: port 0 first, then port 1, then port 0 again.
    op_m[0] = 2'b00; amt_m[0] = 5'd3;  data_m[0] = 32'h0000_0001;
    op_m[1] = 2'b10; amt_m[1] = 5'd31; data_m[1] = 32'h8000_0000;
    issue(2'b11);
    chk("arb_first_data", res_data, 32'h0000_0008);
    issue(2'b10);
    chk("arb_p1_data", res_data, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    held = res_data;
    chk("hold_valid", {31'd0, res_valid}, 32'd0);
    chk("hold_data", held, 32'hFFFF_FFFF);
    op_m[0] = 2'b00; amt_m[0] = 5'd2;  data_m[0] = 32'h0000_0003;
    op_m[1] = 2'b01; amt_m[1] = 5'd31; data_m[1] = 32'h8000_0000;
    issue(2'b11);
    chk("alt_p0", g_m, 0);
    chk("sll2_data", res_data, 32'h0000_000C);
    issue(2'b10);
    chk("srl31_data", res_data, 32'h0000_0001);

    op_m[1] = 2'b10; amt_m[1] = 5'd0; data_m[1] = 32'hDEAD_BEEF;
    issue(2'b10);
    op_m[0] = 2'b00; amt_m[0] = 5'd5; data_m[0] = 32'h0000_0001;
    issue(2'b01);
    chk("odd_data", res_data, 32'h0000_0020);
    op_m[0] = 2'b11; amt_m[0] = 5'd1; data_m[0] = 32'h8000_0001;
    issue(2'b01);

    // Abort a long op with reset, then a fresh port-1 request right after.
    @(negedge clk);
    op_m[0] = 2'b10; amt_m[0] = 5'd31; data_m[0] = 32'h8123_4567;
    drive(2'b01);
    #1;
    chk("abort_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_busy", {30'd0, busy, res_valid}, 32'd2);
    end
    rst = 1'b1;
    op_m[1] = 2'b00; amt_m[1] = 5'd4; data_m[1] = 32'h0000_0F0F;
    drive(2'b10);
    @(negedge clk);
    chk("abort_busy0", {31'd0, busy}, 32'd0);
    chk("abort_ready0", {30'd0, req_ready}, 32'd0);
    chk("abort_data0", res_data, 32'd0);
    chk("abort_nvalid", {31'd0, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_m = 1'b1;
    issue(2'b10);
    chk("post_rst_data", res_data, 32'h0000_F0F0);

    pend = 2'b00;
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          op_m[p]   = 2'($urandom_range(0, 3));
          amt_m[p]  = 5'($urandom_range(0, 31));
          data_m[p] = $urandom;
        end
      end
      mask = pend | 2'($urandom_range(1, 3));
      issue(mask);
      pend = mask & ~(2'b01 << g_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
# shift_sched

Time-shared iterative shift controller. It arbitrates between two requesters, the branch-offset path (port 0) and the ALU shift-instruction path (port 1), for one 32-bit shift stage. The stage moves the operand by at most 2 bit positions per cycle, and the controller sequences it until the requested amount is consumed. It sits beside the ALU in the datapath and returns each result with the ID of the requester that issued it.

## Interface
Parameters:
- `W`, 32: operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  2: bit i means requester i presents an operation.
- `req_ready`  out  2: bit i means requester i's operation is accepted this cycle.
- `req_op`  in  4: {op1, op0}, 2 bits per port. 00 = SLL, 01 = SRL, 10 = SRA, 11 = treated as SLL.
- `req_amt`  in  10: {amt1, amt0}, 5 bits per port; the shift amount, 0..31.
- `req_data`  in  64: {data1, data0}, 32 bits per port.
- `res_valid`  out  1: one-cycle pulse; the result is valid.
- `res_id`  out  1: the requester that owns the result.
- `res_data`  out  32: the shifted result.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Handshake: a transfer occurs when `req_valid[i] & req_ready[i]`.
  - The requester holds op/amt/data stable while valid is high.
  - The requester drops valid (or presents a new op) after the transfer.
- `req_ready[i]` is high only in IDLE, and only for the granted port. The path from `req_valid` to `req_ready` is combinational.
- Round-robin arbitration:
  - A `last` register resets to 1, so port 0 wins the first contention.
  - When both ports are valid, the port other than `last` is granted.
  - When one port is valid, that port is granted.
  - `last` updates on every accept.
- On accept:
  - The controller latches data, op, amt and owner ID.
  - If amt = 0, the next state is DONE. Otherwise it is SHIFT, with `rem` = amt.
- SHIFT, each cycle:
  - If `rem` >= 2: shift by 2 and `rem` -= 2. Otherwise: shift by 1 and `rem` -= 1.
  - When the new `rem` = 0, the next state is DONE.
- Fill rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: replicate bit 31 on every step.
- DONE:
  - `res_valid` = 1 for exactly one cycle.
  - `res_data` holds the working register; `res_id` holds the owner.
  - The next state is IDLE.
- `res_data` and `res_id` hold their values after the pulse until the next DONE.
- `req_valid` is ignored outside IDLE. A requester waiting during SHIFT/DONE simply keeps valid high.
- Reset mid-operation:
  - Returns to IDLE and discards the operation; no `res_valid` is produced.
  - Clears all outputs and sets `last` = 1.

## Timing
- Reset values:
  - `req_ready` = 00.
  - `res_valid` = 0, `res_id` = 0, `res_data` = 0, `busy` = 0.
- Accept on edge E0. SHIFT occupies ceil(amt/2) cycles; `res_valid` is high in cycle ceil(amt/2)+1 after E0.
  - amt = 0 gives 1 cycle.
  - amt = 31 gives 17 cycles.
- Minimum spacing between accepts is latency + 1 cycles, because IDLE is always visited for at least one cycle.
- `busy` is high from the cycle after the accept through the DONE cycle inclusive.

## Configuration
- `SHIFT_STEP2_EN`
  - Defined: the stage moves up to 2 positions per cycle, as described above.
  - Undefined: the stage moves exactly 1 position per cycle. SHIFT lasts amt cycles, so latency = amt + 1 (amt = 31 gives 32 cycles).
- Results are identical in both builds; only the cycle count differs.

## Test plan
- Port 0, SLL, data 0x0000_0003, amt 2 → `res_data` 0x0000_000C, `res_id` 0, `res_valid` 2 cycles after accept (1 SHIFT cycle).
- Port 1, SRA, data 0x8000_0000, amt 31 → 0xFFFF_FFFF, `res_id` 1.
  - Latency 17 cycles with `SHIFT_STEP2_EN`, 32 without.
  - SRL with the same inputs → 0x0000_0001.
- Both ports valid from reset:
  - Port 0 is granted first (SLL 0x1, amt 3 → 0x8).
  - Port 1 is granted in the IDLE cycle after its DONE.
  - Both valid again: port 0 is granted, since `last` alternates.
- amt 0, data 0xDEAD_BEEF, op SRA → 0xDEAD_BEEF, `res_valid` 1 cycle after accept, `busy` high for 1 cycle.
- Odd amount, SLL 0x0000_0001, amt 5 → 0x0000_0020 after 3 SHIFT cycles (steps 2, 2, 1).
- Assert `rst` during SHIFT of a 31-bit op:
  - Next cycle: `busy` = 0, `req_ready` = 00, `res_data` = 0.
  - No `res_valid` pulse ever appears for the aborted op.
  - A fresh port-1 request is accepted in the first cycle after reset deasserts.
